// File: rtl/axi_rd_arb_pkg.sv
// Shared types and helpers for the AXI read-channel round-robin arbiter.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;

    // AXI arsize encoding for a bus of dsize bits: log2(bytes per beat).
    function automatic logic [2:0] size_of(input int unsigned dsize);
        return 3'($clog2(dsize / 8));
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after the last winner.
module rr_pick #(
    parameter int unsigned NUM = 4,
    parameter int unsigned IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  last,
    output logic           found,
    output logic [IW-1:0]  win
);

    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM; k++) begin
            idx = (32'(last) + 32'd1 + k) % NUM;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between NUM requesters.
// Optional per-requester completion counters: define AXI_RD_ARB_STATS_EN.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned ASIZE  = 32,
    parameter int unsigned DSIZE  = 64,
    parameter int unsigned LSIZE  = 8,
    parameter int unsigned NUM    = 4,
    parameter int unsigned IDSIZE = 4
) (
    input  logic                  axi_aclk,
    input  logic                  axi_rst,
    input  logic [NUM-1:0]        req_valid,
    output logic [NUM-1:0]        req_ready,
    input  logic [NUM*ASIZE-1:0]  req_addr,
    input  logic [NUM*LSIZE-1:0]  req_len,
    output logic [NUM-1:0]        rsp_valid,
    input  logic [NUM-1:0]        rsp_ready,
    output logic [DSIZE-1:0]      rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic [IDSIZE-1:0]     m_arid,
    output logic [ASIZE-1:0]      m_araddr,
    output logic [LSIZE-1:0]      m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [IDSIZE-1:0]     m_rid,
    input  logic [DSIZE-1:0]      m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  busy
`ifdef AXI_RD_ARB_STATS_EN
    ,
    output logic [NUM*16-1:0]     grant_cnt
`endif
);

    localparam int unsigned IW = $clog2(NUM);

    state_t            state, state_n;
    logic [IW-1:0]     g;
    logic [IW-1:0]     last;
    logic [ASIZE-1:0]  addr_q;
    logic [LSIZE-1:0]  len_q;
    logic              found;
    logic [IW-1:0]     win;
    logic              done;

    rr_pick #(.NUM(NUM), .IW(IW)) u_pick (
        .req   (req_valid),
        .last  (last),
        .found (found),
        .win   (win)
    );

    assign m_arid    = IDSIZE'(g);
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = size_of(DSIZE);
    assign m_arburst = BURST_INCR;
    assign busy      = (state != IDLE);
    assign done      = (state == DATA) && m_rvalid && rsp_ready[g] && m_rlast;

    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            state  <= IDLE;
            g      <= '0;
            last   <= IW'(NUM - 1);
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                g      <= win;
                addr_q <= req_addr[32'(win)*ASIZE +: ASIZE];
                len_q  <= req_len[32'(win)*LSIZE +: LSIZE];
            end
            if (done) begin
                last <= g;
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        m_arvalid = 1'b0;
        rsp_valid = '0;
        m_rready  = 1'b0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    state_n        = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                rsp_valid[g] = m_rvalid;
                m_rready     = rsp_ready[g];
                rsp_data     = m_rdata;
                rsp_last     = m_rlast;
                // Beats are routed to the grant regardless of rid; a stray rid is flagged.
                rsp_err      = (m_rresp != 2'b00) || (m_rid != IDSIZE'(g));
                if (done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef AXI_RD_ARB_STATS_EN
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            grant_cnt <= '0;
        end else if (done) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                if (g == IW'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter; exercises AXI_RD_ARB_STATS_EN when defined.
module tb_axi_rd_arbiter;

    logic          axi_aclk;
    logic          axi_rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_addr;
    logic [31:0]   req_len;
    logic [3:0]    rsp_valid;
    logic [3:0]    rsp_ready;
    logic [63:0]   rsp_data;
    logic          rsp_last;
    logic          rsp_err;
    logic [3:0]    m_arid;
    logic [31:0]   m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready;
    logic [3:0]    m_rid;
    logic [63:0]   m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic          busy;
`ifdef AXI_RD_ARB_STATS_EN
    logic [63:0]   grant_cnt;
`endif

    axi_rd_arbiter #(
        .ASIZE(32), .DSIZE(64), .LSIZE(8), .NUM(4), .IDSIZE(4)
    ) dut (
        .axi_aclk  (axi_aclk),
        .axi_rst   (axi_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .busy      (busy)
`ifdef AXI_RD_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct {
        int unsigned r;
        logic [31:0] addr;
        logic [7:0]  len;
        int unsigned ar_delay;
        int          err_beat;
        int          rid_beat;
        bit          toggle;
        logic [3:0]  exp_arid;
        int unsigned exp_beats;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        err;
        logic [3:0]  who;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    initial begin
        #500000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h req=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [31:0] a, input int unsigned b);
        return {a, 32'hC0DE0000 + b};
    endfunction

    task automatic idle_slave();
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rresp   = 2'b00;
        m_rid     = '0;
        m_rdata   = '0;
        rsp_ready = '0;
    endtask

    task automatic do_reset();
        axi_rst   = 1'b1;
        req_valid = '0;
        idle_slave();
        repeat (2) @(posedge axi_aclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_arid", m_arid, 0);
        axi_rst = 1'b0;
        sb.delete();
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_data"}, rsp_data, e.data);
            chk({name, "_last"}, rsp_last, e.last);
            chk({name, "_err"}, rsp_err, e.err);
            chk({name, "_route"}, rsp_valid, 64'(4'b0001 << e.who));
        end
    endtask

    task automatic run_txn(input vec_t v);
        int unsigned b;
        int unsigned cyc;
        bit pushed;
        exp_t e;
        req_valid = '0;
        req_valid[v.r] = 1'b1;
        req_addr[v.r*32 +: 32] = v.addr;
        req_len[v.r*8 +: 8]    = v.len;
        #1;
        chk("idle_busy", busy, 0);
        chk("req_ready", req_ready, 64'(4'b0001 << v.r));
        @(posedge axi_aclk); #1;
        req_valid = '0;
        m_arready = 1'b0;
        for (int unsigned d = 0; d <= v.ar_delay; d++) begin
            if (d == v.ar_delay) m_arready = 1'b1;
            #1;
            chk("arvalid", m_arvalid, 1);
            chk("araddr", m_araddr, v.addr);
            chk("arlen", m_arlen, v.len);
            chk("arid", m_arid, v.exp_arid);
            chk("arsize", m_arsize, 3);
            chk("arburst", m_arburst, 2'b01);
            chk("addr_busy", busy, 1);
            @(posedge axi_aclk); #1;
        end
        m_arready = 1'b0;
        b = 0;
        cyc = 0;
        pushed = 1'b0;
        while (b < v.exp_beats && cyc < 64) begin
            m_rvalid = 1'b1;
            m_rdata  = data_of(v.addr, b);
            m_rlast  = (b == v.exp_beats - 1);
            m_rresp  = (int'(b) == v.err_beat) ? 2'b10 : 2'b00;
            m_rid    = (int'(b) == v.rid_beat) ? 4'(v.r + 1) : 4'(v.r);
            rsp_ready = '0;
            rsp_ready[v.r] = v.toggle ? (cyc % 2 == 0) : 1'b1;
            if (!pushed) begin
                e.data = data_of(v.addr, b);
                e.last = (b == v.exp_beats - 1);
                e.err  = (int'(b) == v.err_beat) || (int'(b) == v.rid_beat);
                e.who  = 4'(v.r);
                sb.push_back(e);
                pushed = 1'b1;
            end
            #1;
            chk("rready_mirror", m_rready, rsp_ready[v.r]);
            chk("rsp_valid", rsp_valid, 64'(4'b0001 << v.r));
            if (rsp_valid[v.r] && rsp_ready[v.r]) begin
                pop_check("beat");
                b++;
                pushed = 1'b0;
            end
            @(posedge axi_aclk); #1;
            cyc++;
        end
        if (b < v.exp_beats) chk("beat_timeout", b, v.exp_beats);
        idle_slave();
        #1;
        chk("end_busy", busy, 0);
        chk("end_rsp_valid", rsp_valid, 0);
        chk("end_sb_empty", sb.size(), 0);
    endtask

    vec_t vecs[5];

    initial begin
        checks   = 0;
        failures = 0;
        req_addr = '0;
        req_len  = '0;
        vecs[0] = '{r:0, addr:32'h0000_1000, len:8'd3, ar_delay:0, err_beat:-1, rid_beat:-1, toggle:1'b0, exp_arid:4'd0, exp_beats:4};
        vecs[1] = '{r:2, addr:32'h0000_2000, len:8'd7, ar_delay:3, err_beat:-1, rid_beat:-1, toggle:1'b1, exp_arid:4'd2, exp_beats:8};
        vecs[2] = '{r:1, addr:32'h0000_3000, len:8'd3, ar_delay:0, err_beat:1,  rid_beat:-1, toggle:1'b0, exp_arid:4'd1, exp_beats:4};
        vecs[3] = '{r:3, addr:32'h0000_4000, len:8'd1, ar_delay:1, err_beat:-1, rid_beat:0,  toggle:1'b0, exp_arid:4'd3, exp_beats:2};
        vecs[4] = '{r:1, addr:32'h0000_5008, len:8'd0, ar_delay:0, err_beat:-1, rid_beat:-1, toggle:1'b0, exp_arid:4'd1, exp_beats:1};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
        end

        // Contention: all four requesters continuously valid, len 0 each.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32] = 32'h100 * (i + 1);
            req_len[i*8 +: 8]    = 8'd0;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            int unsigned w;
            exp_t e;
            w = k % 4;
            #1;
            chk("rr_ready", req_ready, 64'(4'b0001 << w));
            @(posedge axi_aclk); #1;
            m_arready = 1'b1;
            #1;
            chk("rr_arid", m_arid, w);
            chk("rr_araddr", m_araddr, 32'h100 * (w + 1));
            @(posedge axi_aclk); #1;
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            m_rlast   = 1'b1;
            m_rid     = 4'(w);
            m_rdata   = data_of(32'h100 * (w + 1), 0);
            rsp_ready = 4'b1111;
            e.data = data_of(32'h100 * (w + 1), 0);
            e.last = 1'b1;
            e.err  = 1'b0;
            e.who  = 4'(w);
            sb.push_back(e);
            #1;
            if (rsp_valid != 0) pop_check("rr_beat");
            else chk("rr_rsp_valid", rsp_valid, 64'(4'b0001 << w));
            @(posedge axi_aclk); #1;
            m_rvalid  = 1'b0;
            m_rlast   = 1'b0;
            rsp_ready = '0;
        end
        req_valid = '0;
        chk("rr_sb_empty", sb.size(), 0);
        @(posedge axi_aclk); #1;
        idle_slave();

        // Reset in the middle of a len 7 burst, after two beats delivered.
        do_reset();
        req_valid = 4'b0010;
        req_addr[32 +: 32] = 32'h0000_6000;
        req_len[8 +: 8]    = 8'd7;
        @(posedge axi_aclk); #1;
        req_valid = '0;
        m_arready = 1'b1;
        @(posedge axi_aclk); #1;
        m_arready = 1'b0;
        for (int unsigned b = 0; b < 3; b++) begin
            exp_t e;
            m_rvalid  = 1'b1;
            m_rlast   = 1'b0;
            m_rid     = 4'd1;
            m_rdata   = data_of(32'h0000_6000, b);
            rsp_ready = 4'b0010;
            if (b < 2) begin
                e.data = m_rdata;
                e.last = 1'b0;
                e.err  = 1'b0;
                e.who  = 4'd1;
                sb.push_back(e);
                #1;
                pop_check("mr_beat");
                @(posedge axi_aclk); #1;
            end else begin
                axi_rst = 1'b1;
                @(posedge axi_aclk); #1;
                axi_rst = 1'b0;
                chk("mr_busy", busy, 0);
                chk("mr_rsp_valid", rsp_valid, 0);
                chk("mr_rready", m_rready, 0);
                chk("mr_arvalid", m_arvalid, 0);
                chk("mr_req_ready", req_ready, 0);
                chk("mr_arid", m_arid, 0);
                chk("mr_araddr", m_araddr, 0);
                chk("mr_rsp_data", rsp_data, 0);
                chk("mr_rsp_last", rsp_last, 0);
            end
        end
        idle_slave();
        sb.delete();
        run_txn('{r:3, addr:32'h0000_7000, len:8'd1, ar_delay:0, err_beat:-1, rid_beat:-1, toggle:1'b0, exp_arid:4'd3, exp_beats:2});

`ifdef AXI_RD_ARB_STATS_EN
        do_reset();
        chk("stats_clear", grant_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            run_txn('{r:1, addr:32'h0000_8000 + 32'(i*64), len:8'd0, ar_delay:0, err_beat:-1, rid_beat:-1, toggle:1'b0, exp_arid:4'd1, exp_beats:1});
        end
        chk("stats_cnt0", grant_cnt[15:0], 0);
        chk("stats_cnt1", grant_cnt[31:16], 5);
        chk("stats_cnt2", grant_cnt[47:32], 0);
        chk("stats_cnt3", grant_cnt[63:48], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
